// File: rtl/ps2_key_decoder_if.sv
// Scan-code input, key bitmap and event-FIFO handshake of the PS/2 key decoder.
// The decoder takes the slave side; the byte source and event consumer sit on the master side.
interface ps2_key_decoder_if;
  logic [7:0] code_in;
  logic       code_valid;
  logic [7:0] key_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_key;
  logic       evt_press;
  logic       overflow;

  modport master (
    output code_in, code_valid, evt_ready,
    input  key_state, evt_valid, evt_key, evt_press, overflow
  );

  modport slave (
    input  code_in, code_valid, evt_ready,
    output key_state, evt_valid, evt_key, evt_press, overflow
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: prefix parser (E0/F0/E1), eight-key pressed
// bitmap and a 4-deep make/break event FIFO with a sticky overflow flag.
module ps2_key_decoder (
  input  logic               clk,
  input  logic               rst,
  ps2_key_decoder_if.slave   bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EXT    = 3'd1;
  localparam logic [2:0] ST_BRK    = 3'd2;
  localparam logic [2:0] ST_EXTBRK = 3'd3;
  localparam logic [2:0] ST_SKIP   = 3'd4;

  // The pause key sends E1 followed by seven more bytes that must be swallowed.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;
  localparam logic [2:0] FIFO_DEPTH = 3'd4;

  logic [2:0] r_state;
  logic [2:0] r_skip_cnt;
  logic [7:0] r_key_state;
  logic       r_overflow;
  logic [3:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;

  logic [2:0] w_next_state;
  logic [2:0] w_next_skip;
  logic       w_resolve;
  logic       w_ext;
  logic       w_brk;
  logic       w_ignore;
  logic       w_mapped;
  logic [2:0] w_key_idx;
  logic       w_push;
  logic       w_pop;
  logic       w_wr_en;
  logic [3:0] w_head;

  assign w_ext    = (r_state == ST_EXT) || (r_state == ST_EXTBRK);
  assign w_brk    = (r_state == ST_BRK) || (r_state == ST_EXTBRK);
  assign w_ignore = (bus.code_in == 8'h00) || (bus.code_in == 8'hAA) ||
                    (bus.code_in == 8'hEE) || (bus.code_in == 8'hFA) ||
                    (bus.code_in == 8'hFE) || (bus.code_in == 8'hFF);

  // Parser next-state: prefixes advance the FSM, any other byte resolves a key.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_next_state = r_state;
    w_next_skip  = r_skip_cnt;
    w_resolve    = 1'b0;
    if (bus.code_valid) begin
      if (r_state == ST_SKIP) begin
        if (r_skip_cnt <= 3'd1) begin
          w_next_state = ST_IDLE;
          w_next_skip  = 3'd0;
        end else begin
          w_next_skip  = r_skip_cnt - 3'd1;
        end
      end else if (w_ignore) begin
        w_next_state = ST_IDLE;
      end else if (bus.code_in == 8'hE0) begin
        w_next_state = ST_EXT;
      end else if (bus.code_in == 8'hF0) begin
        w_next_state = w_ext ? ST_EXTBRK : ST_BRK;
      end else if ((bus.code_in == 8'hE1) && (r_state == ST_IDLE)) begin
        w_next_state = ST_SKIP;
        w_next_skip  = PAUSE_TAIL;
      end else begin
        w_resolve    = 1'b1;
        w_next_state = ST_IDLE;
      end
    end
  end

  // Key map: arrows only count with the E0 prefix, the others only without it.
  always_comb begin
    w_mapped  = 1'b1;
    w_key_idx = 3'd0;
    case ({w_ext, bus.code_in})
      {1'b1, 8'h75}: w_key_idx = 3'd0;
      {1'b1, 8'h72}: w_key_idx = 3'd1;
      {1'b1, 8'h6B}: w_key_idx = 3'd2;
      {1'b1, 8'h74}: w_key_idx = 3'd3;
      {1'b0, 8'h29}: w_key_idx = 3'd4;
      {1'b0, 8'h5A}: w_key_idx = 3'd5;
      {1'b0, 8'h76}: w_key_idx = 3'd6;
      {1'b0, 8'h1D}: w_key_idx = 3'd7;
      default:       w_mapped  = 1'b0;
    endcase
  end

  // An event is produced only when the key's bitmap bit actually changes,
  // which suppresses typematic repeats and stray breaks.
  assign w_push  = w_resolve && w_mapped && (r_key_state[w_key_idx] == w_brk);
  assign w_pop   = (r_count != 3'd0) && bus.evt_ready;
  assign w_wr_en = w_push && ((r_count != FIFO_DEPTH) || w_pop);

  // Parser state, key bitmap, FIFO pointers/count and overflow flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_skip_cnt  <= 3'd0;
      r_key_state <= 8'h00;
      r_overflow  <= 1'b0;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_count     <= 3'd0;
    end else begin
      r_state    <= w_next_state;
      r_skip_cnt <= w_next_skip;
      if (w_push) begin
        r_key_state[w_key_idx] <= ~w_brk;
      end
      if (w_push && !w_wr_en) begin
        r_overflow <= 1'b1;
      end
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count gates every read, so stale contents are never visible.
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {w_key_idx, ~w_brk};
    end
  end

  assign w_head         = r_mem[r_rd_ptr];
  assign bus.key_state  = r_key_state;
  assign bus.evt_valid  = (r_count != 3'd0);
  assign bus.evt_key    = (r_count != 3'd0) ? w_head[3:1] : 3'd0;
  assign bus.evt_press  = (r_count != 3'd0) ? w_head[0]   : 1'b0;
  assign bus.overflow   = r_overflow;

endmodule
